// File: rtl/rv32i_types.sv
// Shared CDB types: the registered broadcast packet and its field widths.
// The packet is sized for the widest supported configuration (8 requesters).
package rv32i_types;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_SRC_W  = 3;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  we;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest set bit,
// rotate the index back. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N-1:0];
    assign any   = |req;

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    // Offset is relative to ptr, so add it back modulo N (N need not be a power of two).
    always_comb begin
        w_sum   = {1'b0, ptr} + {1'b0, w_off};
        gnt_idx = w_sum[IW-1:0];
        if (w_sum >= (IW + 1)'(N)) begin
            gnt_idx = IW'(w_sum - (IW + 1)'(N));
        end
        gnt          = '0;
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Round-robin arbiter sharing the CDB / regfile write port among NUM_REQ completion sources.
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_wb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic                      freeze_stall,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      cdb_we,
    output logic [IDX_W-1:0]          cdb_src,
    output logic [31:0]               stat_stall,
    output logic [31:0]               stat_conflict
);

    cdb_pkt_t           r_pkt;
    logic               r_valid;
    logic [IDX_W-1:0]   r_rrPtr;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gntIdx;
    logic               w_any;
    logic               w_slotFree;
    logic               w_grantEn;
    logic               w_handshake;
    logic [TAG_W-1:0]   w_selTag;
    logic [DATA_W-1:0]  w_selData;
    logic               w_selWe;

    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
        .req     (req_valid),
        .ptr     (r_rrPtr),
        .gnt     (w_gnt),
        .gnt_idx (w_gntIdx),
        .any     (w_any)
    );

    // Reset also suppresses the grant so req_ready reads 0 while rst is held.
    assign w_slotFree  = !r_valid || !freeze_stall;
    assign w_grantEn   = w_slotFree && !flush && !rst;
    assign w_handshake = w_grantEn && w_any;
    assign req_ready   = w_grantEn ? w_gnt : '0;

    always_comb begin
        w_selTag  = '0;
        w_selData = '0;
        w_selWe   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gntIdx == IDX_W'(i)) begin
                w_selTag  = req_tag[i*TAG_W +: TAG_W];
                w_selData = req_data[i*DATA_W +: DATA_W];
                w_selWe   = req_we[i];
            end
        end
    end

    // Flush wins over everything; an empty or consumed slot refills on a handshake,
    // otherwise a consumed slot drops valid but keeps its payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt   <= '0;
            r_valid <= 1'b0;
            r_rrPtr <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_handshake) begin
            r_valid    <= 1'b1;
            r_pkt.tag  <= CDB_TAG_W'(w_selTag);
            r_pkt.data <= CDB_DATA_W'(w_selData);
            r_pkt.we   <= w_selWe && (w_selTag != '0);
            r_pkt.src  <= CDB_SRC_W'(w_gntIdx);
            r_rrPtr    <= (w_gntIdx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gntIdx + 1'b1;
        end else if (r_valid && !freeze_stall) begin
            r_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_valid;
    assign cdb_tag   = TAG_W'(r_pkt.tag);
    assign cdb_data  = DATA_W'(r_pkt.data);
    assign cdb_we    = r_pkt.we;
    assign cdb_src   = IDX_W'(r_pkt.src);

`ifdef CDB_ARB_STATS_EN
    logic [31:0] r_statStall;
    logic [31:0] r_statConflict;

    // Saturating event counters: held-slot cycles and multi-requester cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_statStall    <= '0;
            r_statConflict <= '0;
        end else begin
            if (r_valid && freeze_stall && (r_statStall != '1)) begin
                r_statStall <= r_statStall + 32'd1;
            end
            if (($countones(req_valid) > 1) && (r_statConflict != '1)) begin
                r_statConflict <= r_statConflict + 32'd1;
            end
        end
    end

    assign stat_stall    = r_statStall;
    assign stat_conflict = r_statConflict;
`else
    assign stat_stall    = '0;
    assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed self-checking bench for cdb_wb_arbiter (4-requester and 3-requester instances).
// Stat expectations follow whether CDB_ARB_STATS_EN is defined.
module tb_cdb_wb_arbiter;

`ifdef CDB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [23:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_we;
    logic         freeze_stall;
    logic         flush;
    logic         cdb_valid;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         cdb_we;
    logic [1:0]   cdb_src;
    logic [31:0]  stat_stall;
    logic [31:0]  stat_conflict;

    logic [2:0]   t3Valid;
    logic [2:0]   t3Ready;
    logic [17:0]  t3Tag;
    logic [95:0]  t3Data;
    logic [2:0]   t3We;
    logic         t3Freeze;
    logic         t3Flush;
    logic         t3CdbValid;
    logic [5:0]   t3CdbTag;
    logic [31:0]  t3CdbData;
    logic         t3CdbWe;
    logic [1:0]   t3CdbSrc;
    logic [31:0]  t3StatStall;
    logic [31:0]  t3StatConflict;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    cdb_wb_arbiter #(.NUM_REQ(4), .DATA_W(32), .TAG_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tag       (req_tag),
        .req_data      (req_data),
        .req_we        (req_we),
        .freeze_stall  (freeze_stall),
        .flush         (flush),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .cdb_we        (cdb_we),
        .cdb_src       (cdb_src),
        .stat_stall    (stat_stall),
        .stat_conflict (stat_conflict)
    );

    cdb_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .TAG_W(6)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (t3Valid),
        .req_ready     (t3Ready),
        .req_tag       (t3Tag),
        .req_data      (t3Data),
        .req_we        (t3We),
        .freeze_stall  (t3Freeze),
        .flush         (t3Flush),
        .cdb_valid     (t3CdbValid),
        .cdb_tag       (t3CdbTag),
        .cdb_data      (t3CdbData),
        .cdb_we        (t3CdbWe),
        .cdb_src       (t3CdbSrc),
        .stat_stall    (t3StatStall),
        .stat_conflict (t3StatConflict)
    );

    task automatic setReq(input int i, input logic [5:0] tag, input logic [31:0] data,
                          input logic we);
        req_tag[i*6 +: 6]    = tag;
        req_data[i*32 +: 32] = data;
        req_we[i]            = we;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst          = 1'b1;
        req_valid    = '0;
        req_tag      = '0;
        req_data     = '0;
        req_we       = '0;
        freeze_stall = 1'b0;
        flush        = 1'b0;
        t3Valid      = '0;
        t3Tag        = '0;
        t3Data       = '0;
        t3We         = '0;
        t3Freeze     = 1'b0;
        t3Flush      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        for (int i = 0; i < 4; i++) setReq(i, 6'(i + 1), 32'hA0 + 32'(i), 1'b1);
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if (cdb_valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_pre_valid: got %b want 1", cdb_valid);
        end
        rst = 1'b1;
        #1;
        nChecks++;
        if (cdb_valid !== 1'b0 || req_ready !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL reset_async: cdb_valid=%b req_ready=%b want 0/0000", cdb_valid, req_ready);
        end
        nChecks++;
        if (stat_stall !== 32'd0 || stat_conflict !== 32'd0 || cdb_tag !== 6'd0 || cdb_data !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL reset_clear: stall=%0d conflict=%0d tag=%0d data=%h want all 0",
                     stat_stall, stat_conflict, cdb_tag, cdb_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nChecks++;
        if (req_ready !== 4'b0001) begin
            nFails++;
            $display("[TB] FAIL reset_first_grant: req_ready=%b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        nChecks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data !== 32'hA0) begin
            nFails++;
            $display("[TB] FAIL reset_first_cdb: valid=%b src=%0d data=%h want 1/0/000000a0",
                     cdb_valid, cdb_src, cdb_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expSrc;
        doReset();
        for (int i = 0; i < 4; i++) setReq(i, 6'(i + 1), 32'h100 + 32'(i), 1'b1);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            expSrc = 2'(i % 4);
            nChecks++;
            if (cdb_valid !== 1'b1 || cdb_src !== expSrc || cdb_data !== 32'h100 + 32'(expSrc)
                || cdb_tag !== 6'(expSrc) + 6'd1 || cdb_we !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL rr_seq%0d: valid=%b src=%0d data=%h tag=%0d we=%b want 1/%0d/%h/%0d/1",
                         i, cdb_valid, cdb_src, cdb_data, cdb_tag, cdb_we,
                         expSrc, 32'h100 + 32'(expSrc), 6'(expSrc) + 6'd1);
            end
        end
        req_valid = '0;
        nChecks++;
        if (stat_conflict !== (STATS ? 32'd8 : 32'd0)) begin
            nFails++;
            $display("[TB] FAIL rr_conflict: got %0d want %0d", stat_conflict, STATS ? 8 : 0);
        end
        @(negedge clk);
        nChecks++;
        if (cdb_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL rr_drain: cdb_valid=%b want 0", cdb_valid);
        end
    endtask

    task automatic test_freeze_hold();
        doReset();
        setReq(2, 6'd5, 32'hDEADBEEF, 1'b1);
        req_valid = 4'b0100;
        #1;
        nChecks++;
        if (req_ready !== 4'b0100) begin
            nFails++;
            $display("[TB] FAIL hold_grant: req_ready=%b want 0100", req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) freeze_stall = 1'b1;
            if (c == 3) begin
                freeze_stall = 1'b0;
                req_valid    = '0;
            end
            #1;
            nChecks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 6'd5 || cdb_data !== 32'hDEADBEEF
                || cdb_we !== 1'b1 || cdb_src !== 2'd2) begin
                nFails++;
                $display("[TB] FAIL hold_cycle%0d: valid=%b tag=%0d data=%h we=%b src=%0d want 1/5/deadbeef/1/2",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_we, cdb_src);
            end
            if (c < 3) begin
                nChecks++;
                if (req_ready !== 4'b0000) begin
                    nFails++;
                    $display("[TB] FAIL hold_ready%0d: req_ready=%b want 0000", c, req_ready);
                end
            end
        end
        @(negedge clk);
        nChecks++;
        if (cdb_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL hold_release: cdb_valid=%b want 0", cdb_valid);
        end
        nChecks++;
        if (stat_stall !== (STATS ? 32'd3 : 32'd0)) begin
            nFails++;
            $display("[TB] FAIL hold_stat: stat_stall=%0d want %0d", stat_stall, STATS ? 3 : 0);
        end
    endtask

    task automatic test_tag_zero();
        doReset();
        setReq(1, 6'd0, 32'h1234, 1'b1);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        nChecks++;
        if (cdb_valid !== 1'b1 || cdb_we !== 1'b0 || cdb_data !== 32'h1234 || cdb_src !== 2'd1) begin
            nFails++;
            $display("[TB] FAIL tag0: valid=%b we=%b data=%h src=%0d want 1/0/00001234/1",
                     cdb_valid, cdb_we, cdb_data, cdb_src);
        end
        @(negedge clk);
        nChecks++;
        if (cdb_valid !== 1'b0 || cdb_data !== 32'h1234) begin
            nFails++;
            $display("[TB] FAIL tag0_drain: valid=%b data=%h want 0/00001234", cdb_valid, cdb_data);
        end
    endtask

    task automatic test_flush();
        doReset();
        setReq(0, 6'd7, 32'h77, 1'b1);
        setReq(2, 6'd9, 32'h99, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0100;
        flush     = 1'b1;
        #1;
        nChecks++;
        if (cdb_valid !== 1'b1 || req_ready !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL flush_ready: cdb_valid=%b req_ready=%b want 1/0000", cdb_valid, req_ready);
        end
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 4'b0101;
        #1;
        nChecks++;
        if (cdb_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL flush_drop: cdb_valid=%b want 0", cdb_valid);
        end
        nChecks++;
        if (req_ready !== 4'b0100) begin
            nFails++;
            $display("[TB] FAIL flush_ptr: req_ready=%b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        nChecks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_data !== 32'h99) begin
            nFails++;
            $display("[TB] FAIL flush_regrant: valid=%b src=%0d data=%h want 1/2/00000099",
                     cdb_valid, cdb_src, cdb_data);
        end
    endtask

    task automatic test_three_req();
        doReset();
        t3Tag  = {6'd3, 6'd2, 6'd1};
        t3Data = {32'h333, 32'h222, 32'h111};
        t3We   = 3'b111;
        t3Valid = 3'b010;
        @(negedge clk);
        t3Valid = 3'b011;
        #1;
        nChecks++;
        if (t3Ready !== 3'b001) begin
            nFails++;
            $display("[TB] FAIL n3_wrap: req_ready=%b want 001", t3Ready);
        end
        @(negedge clk);
        #1;
        nChecks++;
        if (t3CdbValid !== 1'b1 || t3CdbSrc !== 2'd0 || t3CdbData !== 32'h111) begin
            nFails++;
            $display("[TB] FAIL n3_cdb: valid=%b src=%0d data=%h want 1/0/00000111",
                     t3CdbValid, t3CdbSrc, t3CdbData);
        end
        nChecks++;
        if (t3Ready !== 3'b010) begin
            nFails++;
            $display("[TB] FAIL n3_ptr: req_ready=%b want 010", t3Ready);
        end
        @(negedge clk);
        t3Valid = '0;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_tag      = '0;
        req_data     = '0;
        req_we       = '0;
        freeze_stall = 1'b0;
        flush        = 1'b0;
        t3Valid      = '0;
        t3Tag        = '0;
        t3Data       = '0;
        t3We         = '0;
        t3Freeze     = 1'b0;
        t3Flush      = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_round_robin();
        test_freeze_hold();
        test_tag_zero();
        test_flush();
        test_three_req();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
